// File: rtl/ramb_port_scheduler_if.sv
// ---------------------------------------------------------------------------
// ramb_port_scheduler_if
// Bus bundle between the port-B scheduler, the VGA pixel fetcher and RAM
// port B.
//
// Signals:
//   vga_req    VGA read request (held by VGA until vga_gnt)
//   vga_addr   VGA read word address
//   vga_gnt    request accepted this cycle
//   vga_rvalid vga_rdata valid (one cycle after vga_gnt)
//   vga_rdata  read data returned to VGA
//   ram_wen    port-B write enable
//   ram_addr   port-B word address
//   ram_din    port-B write data
//   ram_dout   port-B read data (synchronous RAM, one cycle after address)
//
// Modports:
//   master  the scheduler, which owns port B
//   slave   the peers around it (VGA requester and the RAM port)
// ---------------------------------------------------------------------------
interface ramb_port_scheduler_if;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport master (
        input  vga_req, vga_addr, ram_dout,
        output vga_gnt, vga_rvalid, vga_rdata, ram_wen, ram_addr, ram_din
    );

    modport slave (
        output vga_req, vga_addr, ram_dout,
        input  vga_gnt, vga_rvalid, vga_rdata, ram_wen, ram_addr, ram_din
    );
endinterface

// File: rtl/ramb_port_scheduler.sv
// ---------------------------------------------------------------------------
// ramb_port_scheduler
// Owns data-RAM port B. Produces the alternating EMG/ECG sample schedule,
// writes each sample into that channel's circular buffer and shares the port
// with VGA pixel reads. VGA wins by default; a pending write is blocked for at
// most MAX_WAIT cycles before it takes the port.
//
// Ports:
//   clock    system clock, rising edge
//   reset    synchronous active-low reset
//   emg_in   current EMG ADC value
//   ecg_in   current ECG ADC value
//   bus      VGA request/response and RAM port-B signals (master side)
//   idx_emg  next EMG buffer index (committed writes)
//   idx_ecg  next ECG buffer index (committed writes)
//   overrun  sticky: a sample was dropped because the previous one was
//            still waiting for the port
// ---------------------------------------------------------------------------
module ramb_port_scheduler #(
    parameter int unsigned SAMPLE_INTERVAL = 125000,
    parameter logic [11:0] EMG_BASE        = 12'h400,
    parameter logic [11:0] ECG_BASE        = 12'h800,
    parameter int unsigned BUF_DEPTH       = 640,
    parameter int unsigned MAX_WAIT        = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  emg_in,
    input  logic [31:0]                  ecg_in,
    ramb_port_scheduler_if.master        bus,
    output logic [9:0]                   idx_emg,
    output logic [9:0]                   idx_ecg,
    output logic                         overrun
);

    localparam int TIMER_W = $clog2(SAMPLE_INTERVAL + 1);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);

    localparam logic [TIMER_W-1:0] TICK_AT  = TIMER_W'(SAMPLE_INTERVAL - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [9:0]         IDX_LAST = 10'(BUF_DEPTH - 1);

    typedef enum logic { IDLE, PEND } state_t;
    typedef enum logic { CH_EMG, CH_ECG } chan_t;

    state_t             state;
    chan_t              chan;
    chan_t              wr_chan;
    logic [TIMER_W-1:0] timer;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [11:0]        cap_addr;
    logic [31:0]        cap_data;
    logic               rvalid_p1;

    logic               tick;
    logic               do_write;
    logic               do_read;
    logic               slot_free;
    logic [9:0]         idx_emg_nxt;
    logic [9:0]         idx_ecg_nxt;
    logic [11:0]        new_addr;

    function automatic logic [9:0] idx_inc(input logic [9:0] idx);
        return (idx == IDX_LAST) ? 10'd0 : idx + 10'd1;
    endfunction

    always_comb begin
        tick     = (timer == TICK_AT);
        // Both grants are masked while reset is low so nothing touches RAM.
        do_write = reset && (state == PEND) &&
                   (!bus.vga_req || (wait_cnt == WAIT_LIM));
        do_read  = reset && bus.vga_req && !do_write;

        // The write commits before a same-cycle capture, so the capture sees
        // the already-advanced index and the slot is free again.
        idx_emg_nxt = (do_write && wr_chan == CH_EMG) ? idx_inc(idx_emg) : idx_emg;
        idx_ecg_nxt = (do_write && wr_chan == CH_ECG) ? idx_inc(idx_ecg) : idx_ecg;
        slot_free   = (state == IDLE) || do_write;
        new_addr    = (chan == CH_EMG) ? EMG_BASE + {2'b00, idx_emg_nxt}
                                       : ECG_BASE + {2'b00, idx_ecg_nxt};
    end

    assign bus.ram_wen    = do_write;
    assign bus.vga_gnt    = do_read;
    assign bus.ram_addr   = do_write ? cap_addr : bus.vga_addr;
    assign bus.ram_din    = cap_data;
    assign bus.vga_rvalid = rvalid_p1;
    // The RAM's own output register is the one-cycle read stage; data is
    // passed only while valid so idle/write cycles present zero.
    assign bus.vga_rdata  = rvalid_p1 ? bus.ram_dout : 32'd0;

    // ---- stage p0 -> p1: schedule, arbitration state, read-valid ----
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            chan      <= CH_EMG;
            wr_chan   <= CH_EMG;
            timer     <= '0;
            wait_cnt  <= '0;
            idx_emg   <= '0;
            idx_ecg   <= '0;
            overrun   <= 1'b0;
            rvalid_p1 <= 1'b0;
        end else begin
            timer     <= tick ? '0 : timer + TIMER_W'(1);
            rvalid_p1 <= do_read;
            idx_emg   <= idx_emg_nxt;
            idx_ecg   <= idx_ecg_nxt;

            if (do_write) begin
                state    <= IDLE;
                wait_cnt <= '0;
            end else if (state == PEND && do_read) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (tick) begin
                chan <= (chan == CH_EMG) ? CH_ECG : CH_EMG;
                if (slot_free) begin
                    state   <= PEND;
                    wr_chan <= chan;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // ---- stage p0 -> p1: captured sample (data path, no reset) ----
    always_ff @(posedge clock) begin
        if (reset && tick && slot_free) begin
            cap_data <= (chan == CH_EMG) ? emg_in : ecg_in;
            cap_addr <= new_addr;
        end
    end

endmodule

// File: tb/tb_ramb_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ramb_port_scheduler
// Directed bench for ramb_port_scheduler. Instance A (MAX_WAIT=8) covers the
// sample schedule, arbitration/starvation, VGA read latency, mid-operation
// reset and buffer wrap. Instance B (MAX_WAIT=15) covers sample overrun.
// ---------------------------------------------------------------------------
module tb_ramb_port_scheduler;

    localparam int SI = 10;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_a = 1'b0;
    logic        reset_b = 1'b0;
    logic [31:0] emg_in  = 32'h111;
    logic [31:0] ecg_in  = 32'h222;
    logic [9:0]  idx_emg_a, idx_ecg_a, idx_emg_b, idx_ecg_b;
    logic        overrun_a, overrun_b;

    int total = 0;
    int bad   = 0;

    ramb_port_scheduler_if bus_a ();
    ramb_port_scheduler_if bus_b ();

    ramb_port_scheduler #(
        .SAMPLE_INTERVAL (SI),
        .EMG_BASE        (12'h400),
        .ECG_BASE        (12'h800),
        .BUF_DEPTH       (640),
        .MAX_WAIT        (8)
    ) dut_a (
        .clock   (clock),
        .reset   (reset_a),
        .emg_in  (emg_in),
        .ecg_in  (ecg_in),
        .bus     (bus_a),
        .idx_emg (idx_emg_a),
        .idx_ecg (idx_ecg_a),
        .overrun (overrun_a)
    );

    ramb_port_scheduler #(
        .SAMPLE_INTERVAL (SI),
        .EMG_BASE        (12'h400),
        .ECG_BASE        (12'h800),
        .BUF_DEPTH       (640),
        .MAX_WAIT        (SI + 5)
    ) dut_b (
        .clock   (clock),
        .reset   (reset_b),
        .emg_in  (emg_in),
        .ecg_in  (ecg_in),
        .bus     (bus_b),
        .idx_emg (idx_emg_b),
        .idx_ecg (idx_ecg_b),
        .overrun (overrun_b)
    );

    assign bus_b.ram_dout = 32'h0;

    // Synchronous RAM model for instance A; unwritten words hold a pattern.
    logic [31:0] mem     [4096];
    bit          written [4096];

    function automatic logic [31:0] init_word(input logic [11:0] a);
        return (a == 12'h123) ? 32'hDEAD : {20'hC0000, a};
    endfunction

    always @(posedge clock) begin
        if (bus_a.ram_wen) begin
            mem[bus_a.ram_addr]     <= bus_a.ram_din;
            written[bus_a.ram_addr] <= 1'b1;
        end
        bus_a.ram_dout <= written[bus_a.ram_addr] ? mem[bus_a.ram_addr]
                                                  : init_word(bus_a.ram_addr);
    end

    typedef struct {
        logic        req;
        logic [11:0] vaddr;
        logic        gnt;
        logic        wen;
        logic [11:0] raddr;
        logic [31:0] din;
        logic        rvalid;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic req, input logic [11:0] addr);
        @(posedge clock);
        #1;
        bus_a.vga_req  = req;
        bus_a.vga_addr = addr;
        @(negedge clock);
    endtask

    // Holds reset low for one edge, then releases it: returns in cycle 0.
    task automatic do_reset_a(input string tag);
        @(posedge clock);
        #1;
        reset_a       = 1'b0;
        bus_a.vga_req = 1'b0;
        @(negedge clock);
        chk({tag, "_rst_wen"}, 32'(bus_a.ram_wen), 32'd0);
        chk({tag, "_rst_gnt"}, 32'(bus_a.vga_gnt), 32'd0);
        @(posedge clock);
        #1;
        reset_a = 1'b1;
        @(negedge clock);
        chk({tag, "_c0_idx_emg"}, 32'(idx_emg_a), 32'd0);
        chk({tag, "_c0_idx_ecg"}, 32'(idx_ecg_a), 32'd0);
        chk({tag, "_c0_overrun"}, 32'(overrun_a), 32'd0);
        chk({tag, "_c0_rvalid"}, 32'(bus_a.vga_rvalid), 32'd0);
        chk({tag, "_c0_rdata"}, bus_a.vga_rdata, 32'd0);
        chk({tag, "_c0_wen"}, 32'(bus_a.ram_wen), 32'd0);
    endtask

    // Cycles 1..last with no VGA traffic: writes at cycles 10 (EMG) and 20 (ECG).
    task automatic run_idle_a(input string tag, input int last);
        for (int c = 1; c <= last; c++) begin
            step_a(1'b0, 12'h000);
            chk($sformatf("%s_c%0d_wen", tag, c), 32'(bus_a.ram_wen),
                32'((c == 10) || (c == 20)));
            if (c == 10) begin
                chk({tag, "_w1_addr"}, 32'(bus_a.ram_addr), 32'h400);
                chk({tag, "_w1_din"}, bus_a.ram_din, 32'h111);
            end
            if (c == 20) begin
                chk({tag, "_w2_addr"}, 32'(bus_a.ram_addr), 32'h800);
                chk({tag, "_w2_din"}, bus_a.ram_din, 32'h222);
            end
        end
    endtask

    initial begin
        int  n_emg;
        bit  wrap_next;

        bus_a.vga_req  = 1'b0;
        bus_a.vga_addr = 12'h000;
        bus_b.vga_req  = 1'b0;
        bus_b.vga_addr = 12'h000;

        // Cycles 30..42: EMG sample (401) pending, VGA requesting continuously.
        for (int k = 0; k < 8; k++)
            tbl[k] = '{req: 1'b1, vaddr: 12'h010 + 12'(k), gnt: 1'b1, wen: 1'b0,
                       raddr: 12'h010 + 12'(k), din: 32'h111, rvalid: (k > 0),
                       rdata: (k > 0) ? {20'hC0000, 12'h010 + 12'(k - 1)} : 32'h0};
        tbl[8]  = '{req: 1'b1, vaddr: 12'h018, gnt: 1'b0, wen: 1'b1, raddr: 12'h401,
                    din: 32'h111, rvalid: 1'b1, rdata: 32'hC0000017};
        tbl[9]  = '{req: 1'b1, vaddr: 12'h123, gnt: 1'b1, wen: 1'b0, raddr: 12'h123,
                    din: 32'h111, rvalid: 1'b0, rdata: 32'h0};
        tbl[10] = '{req: 1'b1, vaddr: 12'h020, gnt: 1'b1, wen: 1'b0, raddr: 12'h020,
                    din: 32'h222, rvalid: 1'b1, rdata: 32'hDEAD};
        tbl[11] = '{req: 1'b0, vaddr: 12'h000, gnt: 1'b0, wen: 1'b1, raddr: 12'h801,
                    din: 32'h222, rvalid: 1'b1, rdata: 32'hC0000020};
        tbl[12] = '{req: 1'b0, vaddr: 12'h000, gnt: 1'b0, wen: 1'b0, raddr: 12'h000,
                    din: 32'h222, rvalid: 1'b0, rdata: 32'h0};

        // Basic schedule.
        do_reset_a("init");
        run_idle_a("sched", 20);
        step_a(1'b0, 12'h000);
        chk("sched_idx_emg", 32'(idx_emg_a), 32'd1);
        chk("sched_idx_ecg", 32'(idx_ecg_a), 32'd1);
        for (int c = 22; c <= 29; c++) step_a(1'b0, 12'h000);

        // Starvation bound, read latency and preloaded read.
        foreach (tbl[k]) begin
            step_a(tbl[k].req, tbl[k].vaddr);
            chk($sformatf("tbl%0d_gnt", k), 32'(bus_a.vga_gnt), 32'(tbl[k].gnt));
            chk($sformatf("tbl%0d_wen", k), 32'(bus_a.ram_wen), 32'(tbl[k].wen));
            chk($sformatf("tbl%0d_addr", k), 32'(bus_a.ram_addr), 32'(tbl[k].raddr));
            chk($sformatf("tbl%0d_rvalid", k), 32'(bus_a.vga_rvalid), 32'(tbl[k].rvalid));
            chk($sformatf("tbl%0d_rdata", k), bus_a.vga_rdata, tbl[k].rdata);
            if (tbl[k].wen)
                chk($sformatf("tbl%0d_din", k), bus_a.ram_din, tbl[k].din);
        end
        chk("tbl_idx_emg", 32'(idx_emg_a), 32'd2);
        chk("tbl_idx_ecg", 32'(idx_ecg_a), 32'd2);
        chk("tbl_overrun", 32'(overrun_a), 32'd0);

        // Capture an EMG sample at cycle 49, then reset while it is pending.
        for (int c = 43; c <= 48; c++) step_a(1'b0, 12'h000);
        step_a(1'b1, 12'h030);
        chk("pre_rst_gnt", 32'(bus_a.vga_gnt), 32'd1);
        do_reset_a("midrst");
        run_idle_a("midrst", 10);

        // EMG buffer wrap: write n lands at cycle 20n-10; 641 writes total.
        n_emg     = 1;
        wrap_next = 1'b0;
        for (int c = 11; c <= 12810; c++) begin
            step_a(1'b0, 12'h000);
            if (wrap_next) begin
                chk("wrap_idx_emg", 32'(idx_emg_a), 32'd0);
                wrap_next = 1'b0;
            end
            if (bus_a.ram_wen && bus_a.ram_addr >= 12'h400 && bus_a.ram_addr < 12'h800) begin
                n_emg++;
                chk($sformatf("emg_wr%0d_addr", n_emg), 32'(bus_a.ram_addr),
                    32'(12'h400 + 12'((n_emg - 1) % 640)));
                if (n_emg == 640) wrap_next = 1'b1;
            end
        end
        chk("wrap_emg_count", 32'(n_emg), 32'd641);

        // Overrun on instance B: VGA requests every cycle, write only after 15 waits.
        @(posedge clock);
        #1;
        bus_b.vga_req  = 1'b1;
        bus_b.vga_addr = 12'h050;
        @(posedge clock);
        #1;
        reset_b = 1'b1;
        @(negedge clock);
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) begin
                @(posedge clock);
                #1;
                @(negedge clock);
            end
            chk($sformatf("ovr_c%0d_gnt", c), 32'(bus_b.vga_gnt), 32'(c != 25));
            chk($sformatf("ovr_c%0d_wen", c), 32'(bus_b.ram_wen), 32'(c == 25));
            chk($sformatf("ovr_c%0d_overrun", c), 32'(overrun_b), 32'(c >= 20));
            if (c == 20) begin
                chk("ovr_drop_idx_ecg", 32'(idx_ecg_b), 32'd0);
                chk("ovr_drop_idx_emg", 32'(idx_emg_b), 32'd0);
            end
            if (c == 25) begin
                chk("ovr_wr_addr", 32'(bus_b.ram_addr), 32'h400);
                chk("ovr_wr_din", bus_b.ram_din, 32'h111);
            end
        end
        chk("ovr_after_idx_emg", 32'(idx_emg_b), 32'd1);
        chk("ovr_after_idx_ecg", 32'(idx_ecg_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
